// File: rtl/uart_tx.sv
// uart_pkg + uart_tx
//
// uart_pkg holds the frame configuration types. The receiver uses the same
// types, so both directions read one configuration source.
//
// uart_tx: UART transmitter. It accepts bytes over a valid/ready handshake
// into a one-entry holding register. Each byte goes out as a frame: a start
// bit, 5..8 data bits LSB first, an optional parity bit, and 1 or 2 stop
// bits. Bit timing comes from the bit_en strobe, so each bit lasts from one
// bit_en edge to the next.
//
// Ports
//   clk           in  sole clock, rising edge
//   rst           in  asynchronous reset, active low
//   bit_en        in  bit strobe; the FSM advances only on edges with bit_en=1
//   tx_data[7:0]  in  byte to send
//   tx_valid      in  tx_data is valid
//   tx_ready      out holding register empty (registered, = !hold_full)
//   num_data_bits in  data bits per frame; clamped to 5..8
//   stop_bits     in  1 or 2 stop bits
//   parity        in  none / odd / even
//   tx            out serial line, registered, idles high
//   tx_busy       out a frame is in progress (state != S_IDLE)
//   tx_done       out one-cycle pulse after the final stop bit ends

package uart_pkg;
  typedef enum logic       {STOP_BITS_1, STOP_BITS_2} stop_bits_t;
  typedef enum logic [1:0] {PARITY_NONE, PARITY_ODD, PARITY_EVEN} parity_t;
endpackage

module uart_tx
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_en,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [3:0] num_data_bits,
  input  stop_bits_t stop_bits,
  input  parity_t    parity,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2
  } state_t;

  state_t     r_state;
  logic       r_hold_full;
  logic [7:0] r_hold_data;
  logic [7:0] r_shift;
  logic [2:0] r_cnt;
  logic [2:0] r_cfg_nm1;   // latched (data bits - 1) for the current frame
  logic       r_cfg_stop2;
  parity_t    r_cfg_par;
  logic       r_par_acc;   // XOR of the data bits sent so far
  logic       r_tx;
  logic       r_busy;
  logic       r_done;

  logic [3:0] w_n;
  logic [2:0] w_nm1;
  logic       w_final;
  logic       w_start;

  // Clamp the requested width into 5..8.
  always_comb begin
    if (num_data_bits < 4'd5)      w_n = 4'd5;
    else if (num_data_bits > 4'd8) w_n = 4'd8;
    else                           w_n = num_data_bits;
  end
  assign w_nm1 = 3'(w_n - 4'd1);

  // The last stop bit of the frame: a waiting byte may start its frame
  // directly from here, with no idle bit in between.
  assign w_final = (r_state == S_STOP1 && !r_cfg_stop2) || (r_state == S_STOP2);
  assign w_start = bit_en && r_hold_full && (r_state == S_IDLE || w_final);

  // tx is registered, so each transition loads the line value for the
  // state being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_hold_full <= 1'b0;
      r_hold_data <= '0;
      r_shift     <= '0;
      r_cnt       <= '0;
      r_cfg_nm1   <= '0;
      r_cfg_stop2 <= 1'b0;
      r_cfg_par   <= PARITY_NONE;
      r_par_acc   <= 1'b0;
      r_tx        <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;

      if (tx_valid && !r_hold_full) begin
        r_hold_full <= 1'b1;
        r_hold_data <= tx_data;
      end

      if (w_start) begin
        // hold_full was 1 here, so no byte is accepted on this edge.
        r_hold_full <= 1'b0;
        r_shift     <= r_hold_data;
        r_cfg_nm1   <= w_nm1;
        r_cfg_stop2 <= (stop_bits == STOP_BITS_2);
        r_cfg_par   <= parity;
        r_par_acc   <= 1'b0;
        r_state     <= S_START;
        r_tx        <= 1'b0;
        r_busy      <= 1'b1;
        if (w_final) r_done <= 1'b1;
      end else if (bit_en) begin
        case (r_state)
          S_IDLE: ;
          S_START: begin
            r_state   <= S_DATA;
            r_cnt     <= r_cfg_nm1;
            r_tx      <= r_shift[0];
            r_shift   <= {1'b0, r_shift[7:1]};
            r_par_acc <= r_par_acc ^ r_shift[0];
          end
          S_DATA: begin
            if (r_cnt == 3'd0) begin
              // All n bits are on the wire and folded into r_par_acc.
              if (r_cfg_par != PARITY_NONE) begin
                r_state <= S_PARITY;
                r_tx    <= (r_cfg_par == PARITY_EVEN) ? r_par_acc : ~r_par_acc;
              end else begin
                r_state <= S_STOP1;
                r_tx    <= 1'b1;
              end
            end else begin
              r_cnt     <= r_cnt - 3'd1;
              r_tx      <= r_shift[0];
              r_shift   <= {1'b0, r_shift[7:1]};
              r_par_acc <= r_par_acc ^ r_shift[0];
            end
          end
          S_PARITY: begin
            r_state <= S_STOP1;
            r_tx    <= 1'b1;
          end
          S_STOP1: begin
            if (r_cfg_stop2) begin
              r_state <= S_STOP2;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
          S_STOP2: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
          default: begin
            r_state <= S_IDLE;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign tx_ready = ~r_hold_full;
  assign tx       = r_tx;
  assign tx_busy  = r_busy;
  assign tx_done  = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx. When a byte is issued, the stimulus pushes
// its hand-computed frame onto a queue. The frame is a string of line
// levels, start bit first. A monitor process waits for a start bit, pops
// the frame and checks it bit by bit at the strobe period. It then checks
// the tx_done pulse in the cycle after the frame.
module tb_uart_tx;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       bit_en;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [3:0] num_data_bits;
  stop_bits_t stop_bits;
  parity_t    parity;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  uart_tx dut (
    .clk(clk), .rst(rst), .bit_en(bit_en), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .num_data_bits(num_data_bits),
    .stop_bits(stop_bits), .parity(parity), .tx(tx), .tx_busy(tx_busy),
    .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out (cycle %0d)", nm, cyc);
  endtask

  // Scoreboard: frame bits, bit period in cycles, expected start-bit cycle
  // (>=0 exact, -1 don't care, -2 must directly follow the previous frame).
  string q_bits[$];
  int    q_per[$];
  int    q_start[$];

  // Bit strobe generator.
  int en_period = 1;
  int ph = 0;
  initial begin
    bit_en = 1'b1;
    forever begin
      @(negedge clk);
      ph++;
      bit_en = (ph % en_period) == 0;
    end
  end

  int done_cnt = 0;
  always @(negedge clk) if (rst && tx_done) done_cnt <= done_cnt + 1;

  // Monitor
  int frames_ok = 0;
  int last_post = -100;
  initial begin : mon
    string fb;
    int    per, es;
    bit    pend, abort;
    pend = 0;
    forever begin
      if (!pend) @(negedge clk);
      pend = 0;
      if (rst === 1'b1 && tx === 1'b0) begin
        if (q_bits.size() == 0) begin
          chk("unexpected_start", 32'(tx), 32'(1));
        end else begin
          fb  = q_bits.pop_front();
          per = q_per.pop_front();
          es  = q_start.pop_front();
          if (es >= 0)       chk("start_latency", cyc, es);
          else if (es == -2) chk("b2b_no_gap", cyc, last_post);
          abort = 0;
          for (int j = 0; j < fb.len() && !abort; j++) begin
            for (int c = 0; c < per && !abort; c++) begin
              if (!(j == 0 && c == 0)) @(negedge clk);
              if (!rst) abort = 1;
              else begin
                chk("frame_bit", 32'(tx), 32'(fb[j] == 8'h31));
                chk("busy_in_frame", 32'(tx_busy), 32'(1));
              end
            end
          end
          if (!abort) begin
            @(negedge clk);
            if (rst) begin
              chk("done_pulse", 32'(tx_done), 32'(1));
              frames_ok++;
              last_post = cyc;
              if (tx === 1'b0) pend = 1;
              else chk("busy_after_frame", 32'(tx_busy), 32'(0));
            end
          end
        end
      end
    end
  end

  task automatic cfg(input logic [3:0] n, input stop_bits_t sb, input parity_t p);
    num_data_bits = n;
    stop_bits     = sb;
    parity        = p;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (tx_ready) begin ok = 1; break; end
    end
    if (!ok) fail_now("ready_timeout");
  endtask

  // mode 0: start bit must be in cycle E+2; 1: don't care; 2: back-to-back
  task automatic send(input logic [7:0] d, input string bits, input int mode);
    bit ok;
    wait_ready(ok);
    if (ok) begin
      tx_data  = d;
      tx_valid = 1'b1;
      @(posedge clk);
      #1;
      q_bits.push_back(bits);
      q_per.push_back(en_period);
      q_start.push_back(mode == 0 ? cyc + 1 : (mode == 2 ? -2 : -1));
      tx_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (q_bits.size() == 0 && !tx_busy && tx_ready) begin ok = 1; break; end
    end
    if (!ok) fail_now("idle_timeout");
    repeat (2) @(negedge clk);
  endtask

  initial begin : stim
    bit ok;
    int n;
    rst = 1'b0;
    tx_valid = 1'b0;
    tx_data = 8'h00;
    cfg(4'd8, STOP_BITS_1, PARITY_NONE);
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'(1));
    chk("rst_ready", 32'(tx_ready), 32'(1));
    chk("rst_busy", 32'(tx_busy), 32'(0));
    chk("rst_done", 32'(tx_done), 32'(0));
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_tx", 32'(tx), 32'(1));
    chk("idle_busy", 32'(tx_busy), 32'(0));

    // 8N1 0xA5
    send(8'hA5, "0101001011", 0);
    wait_idle();

    // 7E2: 0x35 -> parity 0, 0x34 -> parity 1
    cfg(4'd7, STOP_BITS_2, PARITY_EVEN);
    send(8'h35, "01010110011", 0);
    wait_idle();
    send(8'h34, "00010110111", 0);
    wait_idle();

    // 5O1 with upper bits set
    cfg(4'd5, STOP_BITS_1, PARITY_ODD);
    send(8'hF3, "01100101", 0);
    wait_idle();

    // Width clamping: 2 -> 5 bits, 15 -> 8 bits
    cfg(4'd2, STOP_BITS_1, PARITY_NONE);
    send(8'h0A, "0010101", 0);
    wait_idle();
    cfg(4'd15, STOP_BITS_1, PARITY_NONE);
    send(8'h81, "0100000011", 0);
    wait_idle();

    // Back-to-back, tx_valid held high across both bytes
    cfg(4'd8, STOP_BITS_1, PARITY_NONE);
    wait_ready(ok);
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    q_bits.push_back("0101010101"); q_per.push_back(1); q_start.push_back(cyc + 1);
    tx_data = 8'h0F;
    chk("ready_drop", 32'(tx_ready), 32'(0));
    wait_ready(ok);
    @(posedge clk);
    #1;
    q_bits.push_back("0111100001"); q_per.push_back(1); q_start.push_back(-2);
    tx_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx_ready) break;
      n++;
    end
    chk("ready_low_cycles", n, 9);
    wait_idle();

    // Strobe pacing: bit_en every 4th cycle, config changed mid-frame
    en_period = 4;
    send(8'hA5, "0101001011", 1);
    repeat (12) @(negedge clk);
    cfg(4'd5, STOP_BITS_2, PARITY_EVEN);
    wait_idle();
    en_period = 1;
    cfg(4'd8, STOP_BITS_1, PARITY_NONE);
    repeat (2) @(negedge clk);

    // Reset mid-frame with a byte held
    send(8'h00, "0000000001", 0);
    send(8'hFF, "0111111111", 2);
    repeat (2) @(negedge clk);
    chk("pre_rst_tx_low", 32'(tx), 32'(0));
    chk("pre_rst_held", 32'(tx_ready), 32'(0));
    #2 rst = 1'b0;
    #1;
    chk("async_rst_tx", 32'(tx), 32'(1));
    chk("async_rst_ready", 32'(tx_ready), 32'(1));
    chk("async_rst_busy", 32'(tx_busy), 32'(0));
    q_bits.delete(); q_per.delete(); q_start.delete();
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    repeat (30) @(negedge clk);
    chk("post_rst_tx", 32'(tx), 32'(1));
    chk("post_rst_busy", 32'(tx_busy), 32'(0));
    chk("post_rst_ready", 32'(tx_ready), 32'(1));

    // 9 frames complete: A5, 35, 34, F3, 0A, 81, 55, 0F, A5 paced
    chk("frames_done", frames_ok, 9);
    chk("done_pulses", done_cnt, 9);
    chk("queue_empty", q_bits.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
